deal_controller: RTL and testbench

DEAL_CONTROLLER -- requirements
Module: deal_controller

---
 rtl/baccarat_pkg.sv | 31 +++
 rtl/banker_rule.sv | 26 ++
 rtl/deal_controller.sv | 84 ++++++++
 tb/tb_deal_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat deal sequencer: FSM state encoding,
// card rank/value constants and the rank-to-value mapping.
package baccarat_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LD_P1  = 4'd1,
    LD_D1  = 4'd2,
    LD_P2  = 4'd3,
    LD_D2  = 4'd4,
    EVAL   = 4'd5,
    LD_P3  = 4'd6,
    EVAL_D = 4'd7,
    LD_D3  = 4'd8,
    DONE   = 4'd9
  } state_e;

  localparam logic [3:0] RANK_TEN    = 4'd10;
  localparam logic [3:0] RANK_KING   = 4'd13;
  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] DRAW_MAX    = 4'd5;

  // Face cards and tens count as zero; rank 0 (no card) is already zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    if (rank >= RANK_TEN && rank <= RANK_KING) begin
      return 4'd0;
    end
    return rank;
  endfunction

endpackage

// File: rtl/banker_rule.sv
// Banker third-card table: purely combinational, zero latency, no flow control.
// Decides whether the banker draws given its score and the player's third card.
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_controller.sv
// Baccarat deal sequencer: one state per cycle, Moore strobes/lights decoded from state.
// No backpressure: the datapath is assumed to absorb each load strobe in its cycle.
module deal_controller
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore_out,
  input  logic [3:0] dscore_out,
  input  logic [3:0] pcard3_out,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       game_over
);

  state_e state_q, state_d;
  logic   banker_draw;

  banker_rule u_banker_rule (
    .dscore (dscore_out),
    .pcard3 (pcard3_out),
    .draw   (banker_draw)
  );

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = LD_P1;
      LD_P1:  state_d = LD_D1;
      LD_D1:  state_d = LD_P2;
      LD_P2:  state_d = LD_D2;
      LD_D2:  state_d = EVAL;
      EVAL: begin
        // A natural on either side ends the hand before any third card.
        if (pscore_out >= NATURAL_MIN || dscore_out >= NATURAL_MIN) begin
          state_d = DONE;
        end else if (pscore_out <= DRAW_MAX) begin
          state_d = LD_P3;
        end else if (dscore_out <= DRAW_MAX) begin
          state_d = LD_D3;
        end else begin
          state_d = DONE;
        end
      end
      LD_P3:  state_d = EVAL_D;
      EVAL_D: state_d = banker_draw ? LD_D3 : DONE;
      LD_D3:  state_d = DONE;
      DONE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_pcard1      = (state_q == LD_P1);
    load_pcard2      = (state_q == LD_P2);
    load_pcard3      = (state_q == LD_P3);
    load_dcard1      = (state_q == LD_D1);
    load_dcard2      = (state_q == LD_D2);
    load_dcard3      = (state_q == LD_D3);
    game_over        = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    if (state_q == DONE) begin
      game_over        = 1'b1;
      player_win_light = (pscore_out >= dscore_out);
      dealer_win_light = (dscore_out >= pscore_out);
    end
  end

endmodule

// File: tb/tb_deal_controller.sv
// Directed bench for deal_controller: per-cycle expected output vectors are queued
// per hand and compared against the DUT on the falling clock edge.
module tb_deal_controller;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic [3:0] pscore_out, dscore_out, pcard3_out;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, game_over;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  string tag = "";

  // {lp1, lp2, lp3, ld1, ld2, ld3, game_over, player_win, dealer_win}
  logic [8:0] exp_q[$];

  deal_controller dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore_out       (pscore_out),
    .dscore_out       (dscore_out),
    .pcard3_out       (pcard3_out),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .game_over        (game_over)
  );

  initial forever #5 slow_clock = ~slow_clock;

  // Expected vectors for cycles 0..ncyc-1 of a hand; -1 means the event never happens.
  task automatic push_hand(input int p3c, input int d3c, input int donec,
                           input bit pw, input bit dw, input int ncyc);
    logic [8:0] rec;
    for (int c = 0; c < ncyc; c++) begin
      rec = 9'd0;
      if (c == 1) rec[8] = 1'b1;
      if (c == 3) rec[7] = 1'b1;
      if (c == p3c) rec[6] = 1'b1;
      if (c == 2) rec[5] = 1'b1;
      if (c == 4) rec[4] = 1'b1;
      if (c == d3c) rec[3] = 1'b1;
      if (donec >= 0 && c >= donec) rec[2:0] = {1'b1, pw, dw};
      exp_q.push_back(rec);
    end
  endtask

  task automatic check();
    logic [8:0] e, o;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s c%0d: scoreboard empty, nothing expected", tag, cyc);
      return;
    end
    e = exp_q.pop_front();
    o = {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
         game_over, player_win_light, dealer_win_light};
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s c%0d: observed %b expected %b", tag, cyc, o, e);
    end
  endtask

  // Hold reset for one edge (expect all-zero outputs), then release into c0.
  task automatic do_reset();
    resetb = 1'b1;
    exp_q.push_back(9'd0);
    @(posedge slow_clock);
    @(negedge slow_clock);
    cyc = -1;
    check();
  endtask

  task automatic run_cycles(input int from_c, input int to_c);
    for (int k = from_c; k <= to_c; k++) begin
      if (k > 0) begin
        @(posedge slow_clock);
        @(negedge slow_clock);
      end else begin
        #1;
      end
      cyc = k;
      check();
    end
  endtask

  task automatic hand(input string name, input logic [3:0] p, input logic [3:0] d,
                      input logic [3:0] c3, input int p3c, input int d3c,
                      input int donec, input bit pw, input bit dw);
    tag = name;
    pscore_out = p;
    dscore_out = d;
    pcard3_out = c3;
    do_reset();
    push_hand(p3c, d3c, donec, pw, dw, donec + 3);
    resetb = 1'b0;
    run_cycles(0, donec + 2);
  endtask

  initial begin
    resetb     = 1'b1;
    pscore_out = 4'd0;
    dscore_out = 4'd0;
    pcard3_out = 4'd0;
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);

    //        name          p     d     c3    p3c d3c done pw dw
    hand("natural",     4'd8, 4'd3, 4'd0,  -1, -1, 6, 1'b1, 1'b0);
    hand("both_draw",   4'd4, 4'd6, 4'd6,   6,  8, 9, 1'b0, 1'b1);
    hand("bank_stand8", 4'd4, 4'd3, 4'd8,   6, -1, 8, 1'b1, 1'b0);
    hand("bank_draw_q", 4'd4, 4'd3, 4'd12,  6,  8, 9, 1'b1, 1'b0);
    hand("play_stand",  4'd6, 4'd5, 4'd0,  -1,  6, 7, 1'b1, 1'b0);
    hand("tie_77",      4'd7, 4'd7, 4'd0,  -1, -1, 6, 1'b1, 1'b1);
    hand("nat_tie_99",  4'd9, 4'd9, 4'd0,  -1, -1, 6, 1'b1, 1'b1);
    hand("d6_ten",      4'd5, 4'd6, 4'd10,  6, -1, 8, 1'b0, 1'b1);
    hand("d4_ace",      4'd3, 4'd4, 4'd1,   6, -1, 8, 1'b0, 1'b1);
    hand("d2_eight",    4'd3, 4'd2, 4'd8,   6,  8, 9, 1'b1, 1'b0);
    hand("both_stand",  4'd6, 4'd7, 4'd0,  -1, -1, 6, 1'b0, 1'b1);
    hand("d5_four",     4'd0, 4'd5, 4'd4,   6,  8, 9, 1'b0, 1'b1);

    // Reset asserted while LD_P3 is active, then a full hand after release.
    tag = "mid_reset";
    pscore_out = 4'd4;
    dscore_out = 4'd6;
    pcard3_out = 4'd6;
    do_reset();
    push_hand(6, 8, 9, 1'b0, 1'b1, 7);
    resetb = 1'b0;
    run_cycles(0, 6);
    do_reset();
    tag = "after_reset";
    push_hand(6, 8, 9, 1'b0, 1'b1, 12);
    resetb = 1'b0;
    run_cycles(0, 11);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_bad++;
      $error("FAIL leftover: observed %0d queued entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
